// File: rtl/mem_bus_controller.sv
// Single-port RAM behind a request/done CPU handshake with address checking and
// programmable wait states. All outputs are registered; busy tracks the FSM state.
module mem_bus_controller #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic        cpu_byte,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_error,
  output logic        busy
);

  localparam int unsigned AW         = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [33:0] ADDR_LIMIT = 34'(MEM_WORDS) << 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic        byte_q, byte_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        mem_we;

  logic [31:0] mem [MEM_WORDS];
  logic [AW-1:0] idx;
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic        chk_err;

  assign idx      = addr_q[AW+1:2];
  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> {addr_q[1:0], 3'b000};
  // Range is compared in 34 bits so addresses near 2^32 can never alias into RAM.
  assign chk_err  = ({2'b00, addr_q} >= ADDR_LIMIT) || (!byte_q && (addr_q[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          write_d = cpu_write;
          byte_d  = cpu_byte;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        err_d = chk_err;
        if (chk_err) begin
          if (!write_q) rdata_d = '0;
          state_d = S_RESP;
        end else if (WAIT_STATES == 0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d   = 4'(WAIT_STATES - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        if (write_q)     mem_we  = 1'b1;
        else if (byte_q) rdata_d = {24'h0, rd_shift[7:0]};
        else             rdata_d = rd_word;
        state_d = S_RESP;
      end
      S_RESP: begin
        done_d  = 1'b1;
        error_d = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // RAM has no reset; a write is only issued from ACCESS, after the address check.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      if (byte_q) mem[idx][{addr_q[1:0], 3'b000} +: 8] <= wdata_q[7:0];
      else        mem[idx] <= wdata_q;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_done  = done_q;
  assign cpu_error = error_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_bus_controller.sv
// Directed bench for mem_bus_controller: instance 0 uses WAIT_STATES=2, instance 1 WAIT_STATES=0.
module tb_mem_bus_controller;

  localparam int WS0 = 2;
  localparam int WS1 = 0;

  logic        clk;
  logic        rst;
  logic [1:0]  req, wr, byt;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [1:0]  done, err, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    bit          chk_rd;
  } exp_t;

  exp_t exp_q[$];

  mem_bus_controller #(.MEM_WORDS(1024), .WAIT_STATES(WS0)) u_dut0 (
    .clk(clk), .rst(rst), .cpu_req(req[0]), .cpu_write(wr[0]), .cpu_byte(byt[0]),
    .cpu_addr(addr[0]), .cpu_wdata(wdata[0]), .cpu_rdata(rdata[0]),
    .cpu_done(done[0]), .cpu_error(err[0]), .busy(busy[0])
  );

  mem_bus_controller #(.MEM_WORDS(1024), .WAIT_STATES(WS1)) u_dut1 (
    .clk(clk), .rst(rst), .cpu_req(req[1]), .cpu_write(wr[1]), .cpu_byte(byt[1]),
    .cpu_addr(addr[1]), .cpu_wdata(wdata[1]), .cpu_rdata(rdata[1]),
    .cpu_done(done[1]), .cpu_error(err[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One transaction on instance u; optional injection of a stray request while in WAIT.
  task automatic xact(input int u, input string tag, input bit w, input bit b,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] er, input bit ee, input bit inject);
    exp_t e;
    exp_t got;
    int   lat;
    bit   seen;
    int   extra;
    int   bad;
    e.rdata  = er;
    e.err    = ee;
    e.lat    = ee ? 2 : 3 + ((u == 0) ? WS0 : WS1);
    e.chk_rd = !w;
    exp_q.push_back(e);
    @(negedge clk);
    req[u] = 1'b1; wr[u] = w; byt[u] = b; addr[u] = a; wdata[u] = d;
    @(posedge clk);
    @(negedge clk);
    req[u] = 1'b0; wr[u] = ~w; byt[u] = ~b; addr[u] = ~a; wdata[u] = ~d;
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done[u]) begin
        lat  = k;
        seen = 1'b1;
        break;
      end
      if (inject) begin
        chk({tag, "_busy"}, 32'(busy[u]), 32'd1);
        if (k == 1) begin
          req[u] = 1'b1; wr[u] = 1'b1; byt[u] = 1'b0; addr[u] = 32'h50; wdata[u] = 32'h00000BAD;
        end else if (k == 2) begin
          req[u] = 1'b0;
        end
      end
    end
    got = exp_q.pop_front();
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, 32'(lat), 32'(got.lat));
      chk({tag, "_error"}, 32'(err[u]), 32'(got.err));
      if (got.chk_rd) chk({tag, "_rdata"}, rdata[u], got.rdata);
    end
    extra = 0;
    bad   = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done[u]) extra++;
      if (!done[u] && err[u]) bad++;
    end
    chk({tag, "_single_pulse"}, 32'(extra), 32'd0);
    chk({tag, "_err_without_done"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    req = '0; wr = '0; byt = '0;
    for (int i = 0; i < 2; i++) begin
      addr[i]  = '0;
      wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("reset_rdata", rdata[i], 32'h0);
      chk("reset_done", 32'(done[i]), 32'd0);
      chk("reset_error", 32'(err[i]), 32'd0);
      chk("reset_busy", 32'(busy[i]), 32'd0);
    end

    // Word write then read.
    xact(0, "wr_10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    xact(0, "rd_10", 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

    // Byte lanes.
    xact(0, "wr_20", 1'b1, 1'b0, 32'h20, 32'h44332211, 32'h0, 1'b0, 1'b0);
    xact(0, "rdb_20", 1'b0, 1'b1, 32'h20, 32'h0, 32'h11, 1'b0, 1'b0);
    xact(0, "rdb_21", 1'b0, 1'b1, 32'h21, 32'h0, 32'h22, 1'b0, 1'b0);
    xact(0, "rdb_22", 1'b0, 1'b1, 32'h22, 32'h0, 32'h33, 1'b0, 1'b0);
    xact(0, "rdb_23", 1'b0, 1'b1, 32'h23, 32'h0, 32'h44, 1'b0, 1'b0);
    xact(0, "wrb_22", 1'b1, 1'b1, 32'h22, 32'hFFFFFFAA, 32'h0, 1'b0, 1'b0);
    xact(0, "rd_20", 1'b0, 1'b0, 32'h20, 32'h0, 32'h44AA2211, 1'b0, 1'b0);

    // Errors and boundaries.
    xact(0, "rd_misalign", 1'b0, 1'b0, 32'h1002, 32'h0, 32'h0, 1'b1, 1'b0);
    xact(0, "rd_20_again", 1'b0, 1'b0, 32'h20, 32'h0, 32'h44AA2211, 1'b0, 1'b0);
    xact(0, "rd_range", 1'b0, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 1'b0);
    xact(0, "wr_range", 1'b1, 1'b0, 32'h1000, 32'h55555555, 32'h0, 1'b1, 1'b0);
    xact(0, "rd_wrap", 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, 1'b0);
    xact(0, "wr_last", 1'b1, 1'b0, 32'hFFC, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
    xact(0, "rd_last", 1'b0, 1'b0, 32'hFFC, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);
    xact(0, "rd_0", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Stray request during WAIT must be ignored.
    xact(0, "wr_50", 1'b1, 1'b0, 32'h50, 32'h0, 32'h0, 1'b0, 1'b0);
    xact(0, "busy_rule", 1'b1, 1'b0, 32'h54, 32'h77777777, 32'h0, 1'b0, 1'b1);
    xact(0, "rd_50", 1'b0, 1'b0, 32'h50, 32'h0, 32'h0, 1'b0, 1'b0);
    xact(0, "rd_54", 1'b0, 1'b0, 32'h54, 32'h0, 32'h77777777, 1'b0, 1'b0);

    // Reset during WAIT of a write.
    xact(0, "wr_40", 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
    xact(0, "rd_10_pre", 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b1; byt[0] = 1'b0; addr[0] = 32'h40; wdata[0] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rdata", rdata[0], 32'h0);
    chk("abort_done", 32'(done[0]), 32'd0);
    chk("abort_error", 32'(err[0]), 32'd0);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    pulses = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done[0]) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    xact(0, "rd_40_after_abort", 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset and request at the same edge: request dropped.
    xact(0, "rd_10_pre2", 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    req[0] = 1'b1; wr[0] = 1'b1; byt[0] = 1'b0; addr[0] = 32'h40; wdata[0] = 32'hFFFF0000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req[0] = 1'b0;
    chk("rst_req_busy", 32'(busy[0]), 32'd0);
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done[0]) pulses++;
    end
    chk("rst_req_no_done", 32'(pulses), 32'd0);
    xact(0, "rd_40_after_drop", 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);

    // Zero wait states.
    xact(1, "ws0_wr_8", 1'b1, 1'b0, 32'h8, 32'hA5A55A5A, 32'h0, 1'b0, 1'b0);
    xact(1, "ws0_rd_8", 1'b0, 1'b0, 32'h8, 32'h0, 32'hA5A55A5A, 1'b0, 1'b0);
    xact(1, "ws0_rdb_b", 1'b0, 1'b1, 32'hB, 32'h0, 32'hA5, 1'b0, 1'b0);
    xact(1, "ws0_rd_err", 1'b0, 1'b0, 32'h1001, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_controller.md
MEM_BUS_CONTROLLER -- requirements
Module: mem_bus_controller

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024: the number of 32-bit words of internal RAM.
REQ-002 The block SHALL have parameter WAIT_STATES, default 2: the number of extra stall cycles per access (0..15).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port list (name, direction, width, meaning) SHALL be:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- cpu_req  in  1  start request, sampled only in IDLE.
- cpu_write  in  1  1 = write, 0 = read.
- cpu_byte  in  1  1 = unsigned byte access, 0 = word access.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data; byte writes use [7:0].
- cpu_rdata  out  32  read data; registered.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_error  out  1  error status, valid while cpu_done=1.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 The FSM SHALL have states IDLE, CHECK, WAIT, ACCESS and RESP.
REQ-006 In IDLE with cpu_req=1, the block SHALL latch cpu_write, cpu_byte, cpu_addr and cpu_wdata, then go to CHECK; later changes on those inputs SHALL have no effect on the transaction.
REQ-007 cpu_req SHALL be ignored in every state except IDLE; there is no queuing.
REQ-008 CHECK SHALL flag an error if either condition holds:
- latched address >= 4*MEM_WORDS;
- word access with address[1:0] != 0.
REQ-009 CHECK transitions SHALL be:
- error: go to RESP;
- no error and WAIT_STATES=0: go to ACCESS;
- otherwise: go to WAIT with the wait counter loaded to WAIT_STATES-1.
REQ-010 WAIT SHALL decrement the counter each cycle and go to ACCESS in the cycle the counter is 0, so WAIT lasts exactly WAIT_STATES cycles.
REQ-011 ACCESS SHALL perform the RAM operation at word index address[31:2], then go to RESP.
REQ-012 Word read: cpu_rdata SHALL be loaded with the full stored word.
REQ-013 Byte read: cpu_rdata SHALL be loaded with {24'h0, selected lane}; lane 0 = bits [7:0] (address[1:0]=0), up to lane 3 = bits [31:24].
REQ-014 Word write SHALL replace the stored word; byte write SHALL modify only the addressed lane with wdata[7:0]; cpu_rdata SHALL be unchanged by writes.
REQ-015 RESP SHALL assert cpu_done=1 for exactly one cycle and cpu_error=1 only if CHECK flagged an error, then return to IDLE.
REQ-016 On an errored read, cpu_rdata SHALL be set to 32'h0; on an errored write, RAM SHALL not be modified.
REQ-017 Latency: a request sampled at edge N SHALL produce cpu_done high in cycle N+3+WAIT_STATES on success, or N+2 on error.
REQ-018 A new request SHALL be accepted at the earliest in the cycle after RESP, when the block is back in IDLE.
REQ-019 cpu_error SHALL be 0 whenever cpu_done=0.
REQ-020 Address 4*MEM_WORDS-4 (last word) SHALL be legal; 4*MEM_WORDS SHALL be an error.
REQ-021 Address wrap-around SHALL not occur: every address >= 4*MEM_WORDS is an error, including 32'hFFFF_FFFC.

Reset
REQ-022 While rst=1 at a rising edge, the block SHALL set:
- state to IDLE;
- cpu_rdata to 32'h0;
- cpu_done, cpu_error and busy to 0;
- the wait counter to 0.
REQ-023 RAM contents SHALL not be affected by reset.
REQ-024 A reset asserted before ACCESS SHALL abort the transaction; no RAM write occurs and no cpu_done pulse is produced.
REQ-025 If rst and cpu_req are both high at the same edge, reset SHALL win and the request SHALL be dropped.

Verification
REQ-026 Word write then read, WAIT_STATES=2: write 32'hDEADBEEF to 0x10, then read 0x10 -> cpu_rdata=32'hDEADBEEF; cpu_done exactly 5 cycles after each request edge; cpu_error=0.
REQ-027 Byte lanes: word 32'h44332211 at 0x20; byte reads of 0x20..0x23 -> 0x11, 0x22, 0x33, 0x44; byte write 0xAA to 0x22, then word read -> 32'h44AA2211.
REQ-028 Errors with MEM_WORDS=1024:
- word read at 0x1002 -> cpu_done and cpu_error high 2 cycles after request, cpu_rdata=0;
- word write at 0x1000 (range) -> cpu_done and cpu_error high 2 cycles after request;
- word read at 0xFFC -> cpu_error=0.
REQ-029 Busy rule: a second cpu_req pulse in WAIT -> ignored; exactly one cpu_done results; busy=1 from CHECK through RESP.
REQ-030 Reset mid-write: reset in WAIT during a write of 32'h12345678 to 0x40 (prior 32'h0) -> no cpu_done, all outputs 0, a later read of 0x40 returns 32'h0.
REQ-031 WAIT_STATES=0: read request -> cpu_done exactly 3 cycles after the request edge.
